// File: rtl/program_loader.sv
// Boot loader: assembles a big-endian byte stream into 32-bit words and writes them to instruction memory.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum word before the image is accepted.
module program_loader #(
   parameter int          MAX_WORDS = 64,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        Start,
   input  logic [7:0]  ByteIn,
   input  logic        ByteValid,
   output logic        ByteReady,
   output logic        MemWE,
   output logic [31:0] MemAddr,
   output logic [31:0] MemData,
   output logic        CPUHold,
   output logic        Done,
   output logic        Error,
   output logic [15:0] WordCount
);

   // Byte stream handshake: a byte moves on a rising edge where ByteValid and ByteReady are both 1;
   // ByteReady depends only on state, so the loader never stalls a byte inside a receiving state.

   typedef enum logic [2:0] {
      S_IDLE,
      S_HEADER,
      S_DATA,
`ifdef LOADER_CHECKSUM_EN
      S_CHECK,
`endif
      S_DONE,
      S_ERROR
   } state_t;

   localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

   state_t      state;
   state_t      next_state;
   logic [1:0]  byte_cnt;
   logic [31:0] word_sh;
   logic [15:0] n_words;
   logic        xfer;
   logic        word_done;
   logic [31:0] full_word;
   logic        start_ok;
   logic        hdr_bad;
   logic        last_data;
`ifdef LOADER_CHECKSUM_EN
   logic [31:0] acc;
`endif

   assign xfer      = ByteValid & ByteReady;
   assign word_done = xfer & (byte_cnt == 2'd3);
   assign full_word = {word_sh[23:0], ByteIn};
   assign start_ok  = Start & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERROR));
   assign hdr_bad   = (full_word[15:0] == 16'd0) | ({1'b0, full_word[15:0]} > MAX_W);
   assign last_data = ((WordCount + 16'd1) == n_words);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (Start) next_state = S_HEADER;
         end
         S_HEADER: begin
            if (word_done) next_state = hdr_bad ? S_ERROR : S_DATA;
         end
         S_DATA: begin
            if (word_done && last_data) begin
`ifdef LOADER_CHECKSUM_EN
               next_state = S_CHECK;
`else
               next_state = S_DONE;
`endif
            end
         end
`ifdef LOADER_CHECKSUM_EN
         S_CHECK: begin
            if (word_done) next_state = (full_word == acc) ? S_DONE : S_ERROR;
         end
`endif
         S_DONE, S_ERROR: begin
            if (Start) next_state = S_HEADER;
         end
         default: next_state = S_IDLE;
      endcase
   end

   // DONE is entered on the edge that issues the last write; Done is masked while that
   // write strobe is still up so the CPU is released only in the following cycle.
   always_comb begin
      ByteReady = 1'b0;
      Done      = 1'b0;
      Error     = 1'b0;
      CPUHold   = 1'b1;
      case (state)
         S_HEADER, S_DATA: ByteReady = 1'b1;
`ifdef LOADER_CHECKSUM_EN
         S_CHECK:          ByteReady = 1'b1;
`endif
         S_DONE: begin
            Done    = ~MemWE;
            CPUHold = MemWE;
         end
         S_ERROR:          Error = 1'b1;
         default:          ByteReady = 1'b0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         byte_cnt  <= 2'd0;
         word_sh   <= 32'd0;
         n_words   <= 16'd0;
         WordCount <= 16'd0;
         MemWE     <= 1'b0;
         MemAddr   <= BASE_ADDR;
         MemData   <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
         acc       <= 32'd0;
`endif
      end else begin
         MemWE <= 1'b0;

         if (start_ok) begin
            byte_cnt <= 2'd0;
         end else if (xfer) begin
            byte_cnt <= byte_cnt + 2'd1;
         end

         if (xfer) begin
            word_sh <= full_word;
         end

         if ((state == S_HEADER) && word_done) begin
            n_words <= full_word[15:0];
            if (!hdr_bad) begin
               WordCount <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
               acc       <= 32'd0;
`endif
            end
         end

         if ((state == S_DATA) && word_done) begin
            MemWE     <= 1'b1;
            MemData   <= full_word;
            MemAddr   <= BASE_ADDR + {14'd0, WordCount, 2'b00};
            WordCount <= WordCount + 16'd1;
`ifdef LOADER_CHECKSUM_EN
            acc       <= acc ^ full_word;
`endif
         end
      end
   end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time loader that sits directly upstream of the multicycle CPU's instruction memory. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them to consecutive word addresses through the instruction-memory write port. It holds the CPU in reset until the image is complete.

## Interface
Parameters:
- MAX_WORDS, 64: largest accepted image, in 32-bit words.
- BASE_ADDR, 32'h0000_0000: byte address of the first written word.

Ports:
- CLK, input, 1: single clock; all state changes on its rising edge.
- RST, input, 1: synchronous, active-high reset.
- Start, input, 1: one-cycle request to begin a load. Honoured only in IDLE, DONE or ERROR.
- ByteIn, input, 8: stream byte, most significant byte first.
- ByteValid, input, 1: ByteIn is valid this cycle.
- ByteReady, output, 1: loader accepts a byte this cycle. A transfer occurs when ByteValid and ByteReady are both 1.
- MemWE, output, 1: one-cycle write strobe to the instruction memory.
- MemAddr, output, 32: byte address of the write, BASE_ADDR + 4*index.
- MemData, output, 32: assembled instruction word.
- CPUHold, output, 1: keeps the CPU in reset while 1.
- Done, output, 1: image loaded successfully.
- Error, output, 1: image rejected.
- WordCount, output, 16: number of data words written so far.

## Operation
- Stream format: one header word N, then N data words. With LOADER_CHECKSUM_EN, one checksum word follows the data words.
- Byte assembly:
  - A 2-bit byte counter, word <= {word[23:0], ByteIn} on each transfer.
  - The 4th transfer completes the word.
  - The byte counter clears on entering HEADER.
- States: IDLE, HEADER, DATA, CHECK (only with the macro), DONE, ERROR.
- IDLE: ByteReady=0, CPUHold=1. Start goes to HEADER.
- HEADER:
  - On word completion, latch N[15:0].
  - N==0 or N>MAX_WORDS goes to ERROR.
  - Otherwise go to DATA. Clear WordCount and the checksum accumulator.
- DATA:
  - Each completed word is registered into MemData; MemAddr = BASE_ADDR + 4*WordCount.
  - MemWE pulses for one cycle, and WordCount increments in that same cycle.
  - After the N-th word, go to CHECK (macro defined) or to DONE.
- DONE:
  - Done=1, CPUHold=0, ByteReady=0.
  - Start re-enters HEADER. Done clears and CPUHold sets in the cycle after Start.
- ERROR:
  - Error=1, CPUHold=1, ByteReady=0.
  - Start re-enters HEADER and clears Error.
- ByteReady=1 in HEADER, DATA and CHECK. The loader never back-pressures inside those states.
- Start is ignored in HEADER, DATA and CHECK. Bytes presented while ByteReady=0 are not consumed.
- MemAddr arithmetic is 32-bit modulo 2^32, with no range check beyond MAX_WORDS.

## Timing
- Reset values: ByteReady 0, MemWE 0, MemAddr BASE_ADDR, MemData 0, CPUHold 1, Done 0, Error 0, WordCount 0, state IDLE, byte counter 0.
- RST mid-load aborts immediately. The next cycle shows the reset values, and no partial-word write is issued.
- Write latency: if the 4th byte of a data word transfers at edge t, MemWE/MemAddr/MemData are valid for the cycle after edge t. They are held for exactly one cycle.
- Completion, without the macro: if the last data word's MemWE is high in cycle c, then Done=1 and CPUHold=0 from cycle c+1.
- Completion, with the macro: the checksum word completes at edge t; Done=1 or Error=1 from the cycle after t. No MemWE is issued for the checksum word.
- Back-to-back words at full byte rate are supported: a MemWE every 4 cycles with no stalls.
- Gaps in ByteValid simply pause assembly. Partial-word state is retained indefinitely.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - A 32-bit accumulator XORs every data word as it is written.
  - The CHECK state receives one extra word. Equal to the accumulator goes to DONE; unequal goes to ERROR.
  - CPUHold stays 1 on mismatch.
- Not defined: no CHECK state and no accumulator. DONE follows the N-th data word directly, and a trailing word would be left unconsumed with ByteReady=0.

## Test plan
- Basic load, BASE_ADDR=0:
  - Stimulus: bytes 00 00 00 02, then 20 01 00 05, then 8C 22 00 04, continuous.
  - Required: MemWE pulses with (0x0, 0x20010005) then (0x4, 0x8C220004); WordCount=2; Done=1 and CPUHold=0 one cycle after the 2nd MemWE.
- Header rejection:
  - Stimulus: header N=0, and separately N=MAX_WORDS+1 (65).
  - Required: Error=1 and CPUHold=1 the cycle after the 4th header byte; no MemWE ever asserted.
- Stalled stream:
  - Stimulus: the basic-load image with ByteValid toggling every other cycle.
  - Required: identical MemWE addresses and data to the basic load; byte order preserved.
- Reset mid-word:
  - Stimulus: RST asserted after 2 bytes of data word 1.
  - Required: reset values the next cycle, no MemWE. A following Start plus a full image loads correctly from address 0.
- Checksum, LOADER_CHECKSUM_EN defined:
  - Stimulus: the basic-load image followed by checksum 0xAC230001.
  - Required: Done=1, with no third MemWE.
  - Stimulus: the same image followed by 0xAC230000.
  - Required: Error=1, CPUHold=1.
- Reload: Start issued in DONE is followed by a 1-word image (N=1, word 0xFFFFFFFF), which must write to address 0x0, and CPUHold must be 1 again during the load.
